i2c_target_regs: RTL and testbench

I2C target (slave) peripheral that consumes the SCL/SDA lines driven by the processor's memory-mapped I2C master and exposes a small byte-wide register bank. It sits directly downstream of the master on the shared bus. It decodes its 7-bit address, accepts a register pointer plus write bytes with auto-increment, and returns register contents on read transactions. The write side is mirrored to a one-cycle strobe interface so system logic can observe updates.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_bus_sync.sv | 39 +++
 rtl/i2c_target_regs.sv | 130 +++++++++++++
 tb/tb_i2c_target_regs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM states, START/STOP SDA edge encodings and byte framing constants
// shared by the I2C master and target blocks.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RMACK     = 4'd8,
        IGNORE    = 4'd9
    } i2c_state_t;

    // {previous, current} synchronized SDA while SCL is held high
    localparam logic [1:0] START_SDA = 2'b10;
    localparam logic [1:0] STOP_SDA  = 2'b01;

    localparam int         BYTE_BITS = 8;
    localparam logic [2:0] LAST_BIT  = 3'(BYTE_BITS - 1);

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronizers plus a delay stage on SCL/SDA, producing
// SCL edge pulses and START/STOP detection.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] synchronizer stages, [2] edge-detect delay; reset to an idle bus
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_high;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda       = sda_q[1];
    assign scl_high  = scl_q[1] & scl_q[2];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_high && sda_q[2:1] == START_SDA;
    assign stop_det  = scl_high && sda_q[2:1] == STOP_SDA;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a byte-wide register bank with an
// auto-incrementing pointer and a system-side write strobe mirror.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 8,
    parameter int         PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_drive_low,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_idx,
    output logic [7:0]       wr_data,
    output logic             busy
);

    logic             sda, scl_rise, scl_fall, start_det, stop_det;
    i2c_state_t       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [7:0]       regs [NUM_REGS];
    logic [7:0]       rx_byte;
    logic             last;
    logic             load_rd;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rd_data = regs[rd_idx];
    assign rx_byte = {shreg[6:0], sda};
    assign last    = bit_cnt == LAST_BIT;
    assign ptr_inc = ptr + PTR_W'(1);
    // Read bytes start on an SCL fall: end of the address ACK, or after a master ACK
    assign load_rd = (state == ADDR_ACK && sda_drive_low && rw) || (state == RMACK && bit_cnt == 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            rw            <= 1'b0;
            ptr           <= '0;
            sda_drive_low <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_idx        <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state         <= IDLE;
                sda_drive_low <= 1'b0;
                busy          <= 1'b0;
            end else if (start_det) begin
                state         <= ADDR;
                bit_cnt       <= '0;
                sda_drive_low <= 1'b0;
            end else if (scl_rise) begin
                if (state inside {ADDR, PTR, WDATA, RDATA}) bit_cnt <= bit_cnt + 3'd1;
                if (state inside {ADDR, PTR, WDATA}) shreg <= rx_byte;
                case (state)
                    ADDR: if (last) begin
                        state <= rx_byte[7:1] == TARGET_ADDR ? ADDR_ACK : IGNORE;
                        busy  <= rx_byte[7:1] == TARGET_ADDR;
                        rw    <= rx_byte[0];
                    end
                    PTR: if (last) begin
                        ptr   <= rx_byte[PTR_W-1:0];
                        state <= PTR_ACK;
                    end
                    WDATA: if (last) begin
                        regs[ptr] <= rx_byte;
                        wr_strobe <= 1'b1;
                        wr_idx    <= ptr;
                        wr_data   <= rx_byte;
                        ptr       <= ptr_inc;
                        state     <= WDATA_ACK;
                    end
                    RMACK: if (sda) begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                    end else begin
                        ptr     <= ptr_inc;
                        bit_cnt <= 3'd1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    // first fall starts the ACK slot, second fall ends it
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        sda_drive_low <= !sda_drive_low;
                        if (sda_drive_low) state <= state == ADDR_ACK ? PTR : WDATA;
                    end
                    RDATA: begin
                        sda_drive_low <= bit_cnt != 3'd0 && !shreg[LAST_BIT - bit_cnt];
                        if (bit_cnt == 3'd0) state <= RMACK;
                    end
                    default: ;
                endcase
                if (load_rd) begin
                    state         <= RDATA;
                    shreg         <= regs[ptr];
                    sda_drive_low <= !regs[ptr][7];
                    bit_cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master driving the target; write strobes
// and read bytes are checked against queued expectations.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int Q = 4;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_in;
    logic       m_sda;
    logic       sda_in;
    logic       sda_drive_low;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic       busy;

    wr_t        wq[$];
    logic [7:0] rq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         drive_cnt = 0;

    assign sda_in = m_sda & ~sda_drive_low;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk           (clk),
        .reset         (reset),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .sda_drive_low (sda_drive_low),
        .rd_idx        (rd_idx),
        .rd_data       (rd_data),
        .wr_strobe     (wr_strobe),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write-strobe monitor: each pulse pops one queued expectation
    always @(negedge clk) begin
        if (sda_drive_low) drive_cnt++;
        if (wr_strobe) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL wr_strobe unexpected: idx %0d data %0h", wr_idx, wr_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                if (wr_idx !== e.idx || wr_data !== e.data) begin
                    n_err++;
                    $display("FAIL wr_strobe: got idx %0d data %0h expected idx %0d data %0h",
                             wr_idx, wr_data, e.idx, e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(6);
        scl_in = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        scl_in = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(Q);
        scl_in = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        tick(Q);
        scl_in = 1'b1;
        tick(2 * Q);
        scl_in = 1'b0;
        tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        scl_in = 1'b1;
        tick(Q);
        b = sda_in;
        tick(Q);
        scl_in = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        check({name, " ack"}, 32'(a), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic mack, input string name);
        logic [7:0] r;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) recv_bit(r[i]);
        send_bit(mack);
        e = rq.pop_front();
        check(name, 32'(r), 32'(e));
    endtask

    task automatic check_reg(input logic [2:0] idx, input logic [7:0] exp, input string name);
        rd_idx = idx;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset  = 1'b1;
        scl_in = 1'b1;
        m_sda  = 1'b1;
        rd_idx = '0;
        tick(3);
        check("reset sda_drive_low", 32'(sda_drive_low), 0);
        check("reset busy", 32'(busy), 0);
        check("reset wr_strobe", 32'(wr_strobe), 0);
        check("reset wr_idx/wr_data", {21'd0, wr_idx, wr_data}, 0);
        for (int i = 0; i < 8; i++) check_reg(3'(i), 8'h00, "reset reg");
        reset = 1'b0;
        tick(4);

        // write burst to reg2/reg3
        wq.push_back('{3'd2, 8'hAA});
        wq.push_back('{3'd3, 8'hBB});
        i2c_start();
        write_byte(8'h84, 1'b0, "burst addr");
        check("burst busy", 32'(busy), 1);
        write_byte(8'h02, 1'b0, "burst ptr");
        write_byte(8'hAA, 1'b0, "burst d0");
        write_byte(8'hBB, 1'b0, "burst d1");
        i2c_stop();
        check("burst busy after stop", 32'(busy), 0);
        check_reg(3'd3, 8'hBB, "burst reg3");
        check_reg(3'd2, 8'hAA, "burst reg2");

        // pointer wrap 7 -> 0
        wq.push_back('{3'd7, 8'h11});
        wq.push_back('{3'd0, 8'h22});
        i2c_start();
        write_byte(8'h84, 1'b0, "wrap addr");
        write_byte(8'h07, 1'b0, "wrap ptr");
        write_byte(8'h11, 1'b0, "wrap d0");
        write_byte(8'h22, 1'b0, "wrap d1");
        i2c_stop();
        check_reg(3'd7, 8'h11, "wrap reg7");
        check_reg(3'd0, 8'h22, "wrap reg0");

        // pointer upper bits discarded: 0xFD -> 5
        wq.push_back('{3'd5, 8'h5A});
        wq.push_back('{3'd6, 8'h3C});
        i2c_start();
        write_byte(8'h84, 1'b0, "trunc addr");
        write_byte(8'hFD, 1'b0, "trunc ptr");
        write_byte(8'h5A, 1'b0, "trunc d0");
        write_byte(8'h3C, 1'b0, "trunc d1");
        i2c_stop();
        check_reg(3'd5, 8'h5A, "trunc reg5");

        // write pointer, repeated START, read two bytes, NACK
        rq.push_back(8'h5A);
        rq.push_back(8'h3C);
        i2c_start();
        write_byte(8'h84, 1'b0, "rd waddr");
        write_byte(8'h05, 1'b0, "rd ptr");
        i2c_start();
        write_byte(8'h85, 1'b0, "rd raddr");
        read_byte(1'b0, "rd byte0 reg5");
        read_byte(1'b1, "rd byte1 reg6");
        check("nack sda released", 32'(sda_drive_low), 0);
        check("nack state", 32'(dut.state), 32'(IGNORE));
        check("nack busy", 32'(busy), 0);
        i2c_stop();

        // address mismatch: no ACK, no drive, no strobe, not busy
        drive_cnt = 0;
        i2c_start();
        write_byte(8'h90, 1'b1, "miss addr");
        check("miss busy", 32'(busy), 0);
        write_byte(8'h01, 1'b1, "miss b1");
        write_byte(8'h77, 1'b1, "miss b2");
        i2c_stop();
        check("miss drive cycles", 32'(drive_cnt), 0);
        check("miss busy after", 32'(busy), 0);

        // reset while the target drives a 0 data bit (reg0 = 0x22)
        i2c_start();
        write_byte(8'h84, 1'b0, "rst waddr");
        write_byte(8'h00, 1'b0, "rst ptr");
        i2c_start();
        write_byte(8'h85, 1'b0, "rst raddr");
        tick(2);
        check("rdata driving low", 32'(sda_drive_low), 1);
        reset = 1'b1;
        #1;
        check("reset releases sda", 32'(sda_drive_low), 0);
        check_reg(3'd0, 8'h00, "reset clears reg0");
        check("reset state", 32'(dut.state), 32'(IDLE));
        m_sda  = 1'b1;
        scl_in = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);

        wq.push_back('{3'd4, 8'h99});
        i2c_start();
        write_byte(8'h84, 1'b0, "post addr");
        write_byte(8'h04, 1'b0, "post ptr");
        write_byte(8'h99, 1'b0, "post d0");
        i2c_stop();
        check_reg(3'd4, 8'h99, "post reg4");
        check_reg(3'd5, 8'h00, "post reg5");
        tick(4);
        check("pending strobes", 32'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
